// File: rtl/coin_wallet_if.sv
// Player-facing signal bundle for coin_wallet: coin/level/reward inputs and balance/status outputs.
// COIN_WALLET_BCD_EN adds the money_tens/money_ones display digits.
interface coin_wallet_if;
  logic       coin_in;
  logic [2:0] level;
  logic       reward_valid;
  logic [6:0] reward_amt;
  logic [6:0] money;
  logic       charged;
  logic       denied;
  logic       playing;
`ifdef COIN_WALLET_BCD_EN
  logic [3:0] money_tens;
  logic [3:0] money_ones;

  modport master (
    output coin_in, level, reward_valid, reward_amt,
    input  money, charged, denied, playing, money_tens, money_ones
  );

  modport slave (
    input  coin_in, level, reward_valid, reward_amt,
    output money, charged, denied, playing, money_tens, money_ones
  );
`else
  modport master (
    output coin_in, level, reward_valid, reward_amt,
    input  money, charged, denied, playing
  );

  modport slave (
    input  coin_in, level, reward_valid, reward_amt,
    output money, charged, denied, playing
  );
`endif
endinterface

// File: rtl/coin_wallet.sv
// Credit bank: owns the saturating player balance, charges one ticket per game start, flags denied starts.
// Optional COIN_WALLET_BCD_EN adds registered BCD digits of the balance.
module coin_wallet #(
  parameter int COIN_VALUE  = 10,
  parameter int TICKET_COST = 10,
  parameter int MAX_MONEY   = 99,
  parameter int INIT_MONEY  = 0
) (
  input  logic          clk,
  input  logic          rst,
  coin_wallet_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DENIED
  } state_t;

  localparam logic [8:0] CoinW   = 9'(COIN_VALUE);
  localparam logic [8:0] TicketW = 9'(TICKET_COST);
  localparam logic [8:0] MaxW    = 9'(MAX_MONEY);
  localparam logic [6:0] InitM   = 7'(INIT_MONEY);

  state_t     state_q, state_d;
  logic [6:0] money_q, money_d;
  logic       charged_q, charged_d;
  logic       denied_q, denied_d;
  logic       coin_q;
  logic [2:0] level_q;
  logic       armed_q;

  logic       coin_evt;
  logic       start_evt;
  logic       end_evt;
  logic       charge;
  logic       reward_ok;
  logic [8:0] sum;

  // armed_q stays low until level has been seen at 0, so a level held through reset cannot start a game
  assign coin_evt  = bus.coin_in & ~coin_q;
  assign start_evt = armed_q && (level_q == 3'd0) && (bus.level != 3'd0);
  assign end_evt   = (bus.level == 3'd0);

  always_comb begin
    state_d   = state_q;
    charged_d = 1'b0;
    denied_d  = 1'b0;
    charge    = 1'b0;
    reward_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_evt) begin
          if ({2'b00, money_q} >= TicketW) begin
            charge    = 1'b1;
            charged_d = 1'b1;
            state_d   = PLAY;
          end else begin
            denied_d = 1'b1;
            state_d  = DENIED;
          end
        end
      end
      PLAY: begin
        reward_ok = bus.reward_valid;
        if (end_evt) state_d = IDLE;
      end
      DENIED: begin
        if (end_evt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Eligibility above uses only money_q; the charge is applied after same-cycle credits, then clamped
  always_comb begin
    sum = {2'b00, money_q}
        + (coin_evt  ? CoinW : 9'd0)
        + (reward_ok ? {2'b00, bus.reward_amt} : 9'd0);
    if (charge) sum = sum - TicketW;
    money_d = (sum > MaxW) ? MaxW[6:0] : sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      money_q   <= InitM;
      charged_q <= 1'b0;
      denied_q  <= 1'b0;
      coin_q    <= 1'b1;
      level_q   <= 3'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      money_q   <= money_d;
      charged_q <= charged_d;
      denied_q  <= denied_d;
      coin_q    <= bus.coin_in;
      level_q   <= bus.level;
      if (bus.level == 3'd0) armed_q <= 1'b1;
    end
  end

  assign bus.money   = money_q;
  assign bus.charged = charged_q;
  assign bus.denied  = denied_q;
  assign bus.playing = (state_q == PLAY);

`ifdef COIN_WALLET_BCD_EN
  localparam logic [3:0] InitTens = 4'(INIT_MONEY / 10);
  localparam logic [3:0] InitOnes = 4'(INIT_MONEY % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  always_comb begin
    tens_d = 4'(money_d / 7'd10);
    ones_d = 4'(money_d % 7'd10);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_q <= InitTens;
      ones_q <= InitOnes;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bus.money_tens = tens_q;
  assign bus.money_ones = ones_q;
`endif

endmodule

// File: tb/tb_coin_wallet.sv
// Directed-vector bench for coin_wallet: stimulus pushes hand-computed expectations into a queue,
// an independent monitor pops and compares them against the DUT outputs every cycle.
module tb_coin_wallet;

  typedef struct {
    logic [6:0] money;
    logic       charged;
    logic       denied;
    logic       playing;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   vectors;
  int   miscompares;

  coin_wallet_if cw ();

  coin_wallet dut (
    .clk (clk),
    .rst (rst),
    .bus (cw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus cycle: drive on the falling edge, queue what the following rising edge must produce
  task automatic applyStimulus(input logic r, input logic c, input logic [2:0] lv,
                               input logic rv, input logic [6:0] amt,
                               input logic [6:0] em, input logic ech, input logic eden,
                               input logic eplay, input string nm);
    exp_t e;
    @(negedge clk);
    rst             = r;
    cw.coin_in      = c;
    cw.level        = lv;
    cw.reward_valid = rv;
    cw.reward_amt   = amt;
    @(posedge clk);
    #1;
    e.money   = em;
    e.charged = ech;
    e.denied  = eden;
    e.playing = eplay;
    e.name    = nm;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic ok;
    vectors++;
    ok = (cw.money === e.money) && (cw.charged === e.charged) &&
         (cw.denied === e.denied) && (cw.playing === e.playing);
`ifdef COIN_WALLET_BCD_EN
    ok = ok && (cw.money_tens === 4'(e.money / 7'd10)) && (cw.money_ones === 4'(e.money % 7'd10));
    if (!ok)
      $display("[TB] FAIL %s: got money=%0d tens=%0d ones=%0d ch=%b den=%b play=%b, want money=%0d ch=%b den=%b play=%b",
               e.name, cw.money, cw.money_tens, cw.money_ones, cw.charged, cw.denied, cw.playing,
               e.money, e.charged, e.denied, e.playing);
`else
    if (!ok)
      $display("[TB] FAIL %s: got money=%0d ch=%b den=%b play=%b, want money=%0d ch=%b den=%b play=%b",
               e.name, cw.money, cw.charged, cw.denied, cw.playing,
               e.money, e.charged, e.denied, e.playing);
`endif
    if (!ok) miscompares++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int exp10;
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b0;
    cw.coin_in      = 1'b1;
    cw.level        = 3'd0;
    cw.reward_valid = 1'b0;
    cw.reward_amt   = 7'd0;

    // Coin held through reset must not count; then fill to saturation
    applyStimulus(0, 1, 0, 0, 0,  0, 0, 0, 0, "rst_hold_a");
    applyStimulus(0, 1, 0, 0, 0,  0, 0, 0, 0, "rst_hold_b");
    applyStimulus(1, 1, 0, 0, 0,  0, 0, 0, 0, "no_spurious_coin");
    applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, "coin_low");
    applyStimulus(1, 1, 0, 0, 0, 10, 0, 0, 0, "coin_1");
    applyStimulus(1, 0, 0, 0, 0, 10, 0, 0, 0, "coin_1_low");
    for (int i = 2; i <= 11; i++) begin
      exp10 = (i * 10 > 99) ? 99 : i * 10;
      applyStimulus(1, 1, 0, 0, 0, 7'(exp10), 0, 0, 0, "coin_fill");
      applyStimulus(1, 0, 0, 0, 0, 7'(exp10), 0, 0, 0, "coin_fill_low");
    end

    // Charge from 20, hold level, reward, end, second charge down to 5
    applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 0, "reset2");
    applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, "reset2_rel");
    applyStimulus(1, 1, 0, 0, 0, 10, 0, 0, 0, "coin_a");
    applyStimulus(1, 0, 0, 0, 0, 10, 0, 0, 0, "coin_a_low");
    applyStimulus(1, 1, 0, 0, 0, 20, 0, 0, 0, "coin_b");
    applyStimulus(1, 0, 0, 0, 0, 20, 0, 0, 0, "coin_b_low");
    applyStimulus(1, 0, 2, 0, 0, 10, 1, 0, 1, "charge");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 2, 0, 0, 10, 0, 0, 1, "hold_no_recharge");
    applyStimulus(1, 0, 2, 1, 5, 15, 0, 0, 1, "reward_5");
    applyStimulus(1, 0, 0, 0, 0, 15, 0, 0, 0, "end_game");
    applyStimulus(1, 0, 1, 0, 0,  5, 1, 0, 1, "charge2");
    applyStimulus(1, 0, 0, 0, 0,  5, 0, 0, 0, "end_game2");

    // Insufficient balance: denied, rewards ignored, non-zero level change is not a start
    applyStimulus(1, 0, 1, 0, 0,  5, 0, 1, 0, "denied");
    applyStimulus(1, 0, 1, 1, 30, 5, 0, 0, 0, "reward_ignored");
    applyStimulus(1, 0, 3, 0, 0,  5, 0, 0, 0, "nonzero_change");
    applyStimulus(1, 0, 0, 0, 0,  5, 0, 0, 0, "denied_to_idle");
    applyStimulus(1, 0, 2, 0, 0,  5, 0, 1, 0, "denied_again");
    applyStimulus(1, 0, 0, 0, 0,  5, 0, 0, 0, "idle_again");

    // Level held non-zero across reset release must not start a game
    applyStimulus(0, 0, 3, 0, 0,  0, 0, 0, 0, "reset3");
    applyStimulus(1, 0, 3, 0, 0,  0, 0, 0, 0, "no_start_after_reset");
    applyStimulus(1, 0, 3, 0, 0,  0, 0, 0, 0, "no_start_hold");
    applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, "level_zero");

    // Coin edge and start in the same cycle, reward saturation, mid-game reset
    applyStimulus(1, 1, 0, 0, 0, 10, 0, 0, 0, "coin_c");
    applyStimulus(1, 0, 0, 0, 0, 10, 0, 0, 0, "coin_c_low");
    applyStimulus(1, 1, 2, 0, 0, 10, 1, 0, 1, "coin_and_charge");
    applyStimulus(1, 0, 2, 1, 80, 90, 0, 0, 1, "reward_80");
    applyStimulus(1, 0, 2, 1, 20, 99, 0, 0, 1, "reward_sat");
    applyStimulus(1, 1, 2, 1, 3,  99, 0, 0, 1, "coin_reward_sat");
    applyStimulus(0, 0, 2, 0, 0,  0, 0, 0, 0, "mid_game_reset");
    applyStimulus(1, 0, 2, 0, 0,  0, 0, 0, 0, "after_reset_lvl");
    applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, "after_reset_zero");

    // Balance of 47 for the display digits
    applyStimulus(1, 1, 0, 0, 0, 10, 0, 0, 0, "coin_d");
    applyStimulus(1, 0, 0, 0, 0, 10, 0, 0, 0, "coin_d_low");
    applyStimulus(1, 0, 1, 0, 0,  0, 1, 0, 1, "charge_to_zero");
    applyStimulus(1, 0, 1, 1, 47, 47, 0, 0, 1, "reward_47");
    applyStimulus(1, 0, 0, 0, 0, 47, 0, 0, 0, "end_47");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
